// File: rtl/crc_attach_param.sv
// crc_attach_param: serial MSB-first CRC engine with attach and check modes.
// One bit per cycle in, registered output stream, CRC appended after data.
module crc_attach_param #(
    parameter int               CRC_W = 24,
    parameter logic [CRC_W-1:0] POLY  = 24'h864CFB,
    parameter logic [CRC_W-1:0] SEED  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MODE,
    input  logic             IN_VALID,
    input  logic             IN_DATA,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic             OUT_VALID,
    output logic             OUT_DATA,
    output logic             OUT_LAST,
    input  logic             OUT_READY,
    output logic [CRC_W-1:0] CRC_VALUE,
    output logic             CRC_DONE,
    output logic             CRC_OK
);
    localparam int CNT_W = $clog2(CRC_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        APPEND
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic [CRC_W-1:0] shift_q, shift_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             ov_q, ov_d;
    logic             od_q, od_d;
    logic             ol_q, ol_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;

    logic             adv;
    logic             in_fire;
    logic             fb;
    logic             mode_cur;
    logic [CRC_W-1:0] lfsr_base;
    logic [CRC_W-1:0] lfsr_upd;

    // A frame always starts from SEED, never from the stale remainder.
    assign adv       = !ov_q || OUT_READY;
    assign IN_READY  = adv && (state_q == IDLE || state_q == DATA);
    assign in_fire   = IN_VALID && IN_READY;
    assign lfsr_base = (state_q == IDLE) ? SEED : lfsr_q;
    assign fb        = IN_DATA ^ lfsr_base[CRC_W-1];
    assign lfsr_upd  = {lfsr_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    assign mode_cur  = (state_q == IDLE) ? MODE : mode_q;

    assign OUT_VALID = ov_q;
    assign OUT_DATA  = od_q;
    assign OUT_LAST  = ol_q;
    assign CRC_VALUE = crc_q;
    assign CRC_DONE  = done_q;
    assign CRC_OK    = ok_q;

    // Next-state: frame sequencing, LFSR update, output register load.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        shift_d = shift_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        done_d  = 1'b0;
        ok_d    = ok_q;

        if (adv) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
        end

        unique case (state_q)
            IDLE, DATA: begin
                if (in_fire) begin
                    ov_d   = 1'b1;
                    od_d   = IN_DATA;
                    ol_d   = 1'b0;
                    lfsr_d = lfsr_upd;
                    if (state_q == IDLE) begin
                        mode_d  = MODE;
                        state_d = DATA;
                    end
                    if (IN_LAST) begin
                        crc_d  = lfsr_upd;
                        done_d = 1'b1;
                        lfsr_d = SEED;
                        if (mode_cur) begin
                            ol_d    = 1'b1;
                            ok_d    = (lfsr_upd == '0);
                            state_d = IDLE;
                        end else begin
                            shift_d = lfsr_upd;
                            cnt_d   = CNT_W'(CRC_W);
                            state_d = APPEND;
                        end
                    end
                end
            end
            APPEND: begin
                if (adv) begin
                    ov_d    = 1'b1;
                    od_d    = shift_q[CRC_W-1];
                    shift_d = {shift_q[CRC_W-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    ol_d    = (cnt_q == CNT_W'(1));
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            shift_q <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= 1'b0;
            ol_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            shift_q <= shift_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: tb/tb_crc_attach_param.sv
// tb_crc_attach_param: scoreboard bench for crc_attach_param.
// Expected streams come from a long-division CRC model.
module tb_crc_attach_param;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MODE = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_DATA = 1'b0;
    logic        IN_LAST = 1'b0;
    logic        OUT_READY = 1'b1;
    logic        IN_READY, OUT_VALID, OUT_DATA, OUT_LAST;
    logic        CRC_DONE, CRC_OK;
    logic [23:0] CRC_VALUE;

    logic        p_valid = 1'b0;
    logic        p_data = 1'b0;
    logic        p_last = 1'b0;
    logic        r16, v16, d16, l16, dn16, ok16;
    logic        r11, v11, d11, l11, dn11, ok11;
    logic [15:0] crc16;
    logic [10:0] crc11;

    int n_pass = 0;
    int n_total = 0;

    bit          exp_d[$];
    bit          exp_l[$];
    bit          got_d[$];
    bit          got_l[$];
    int          got_done;
    bit          rdy_append;
    logic [23:0] got_crc;
    logic        got_ok;

    always #5 CLK = ~CLK;

    crc_attach_param dut (
        .CLK(CLK), .RST(RST), .MODE(MODE),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
        .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY), .CRC_VALUE(CRC_VALUE),
        .CRC_DONE(CRC_DONE), .CRC_OK(CRC_OK)
    );

    crc_attach_param #(.CRC_W(16), .POLY(16'h1021), .SEED(16'h0)) dut16 (
        .CLK(CLK), .RST(RST), .MODE(1'b0),
        .IN_VALID(p_valid), .IN_DATA(p_data), .IN_LAST(p_last),
        .IN_READY(r16), .OUT_VALID(v16), .OUT_DATA(d16),
        .OUT_LAST(l16), .OUT_READY(1'b1), .CRC_VALUE(crc16),
        .CRC_DONE(dn16), .CRC_OK(ok16)
    );

    crc_attach_param #(.CRC_W(11), .POLY(11'h621), .SEED(11'h0)) dut11 (
        .CLK(CLK), .RST(RST), .MODE(1'b0),
        .IN_VALID(p_valid), .IN_DATA(p_data), .IN_LAST(p_last),
        .IN_READY(r11), .OUT_VALID(v11), .OUT_DATA(d11),
        .OUT_LAST(l11), .OUT_READY(1'b1), .CRC_VALUE(crc11),
        .CRC_DONE(dn11), .CRC_OK(ok11)
    );

    // Remainder of msg * x^w divided by (x^w + poly), by long division.
    function automatic logic [31:0] model_crc(input bit m[$], input int w,
                                              input logic [31:0] poly);
        bit a[$];
        logic [31:0] r;
        a = m;
        for (int i = 0; i < w; i++) a.push_back(1'b0);
        for (int i = 0; i < m.size(); i++) begin
            if (a[i]) begin
                a[i] = 1'b0;
                for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
            end
        end
        r = '0;
        for (int j = 0; j < w; j++) r = {r[30:0], a[m.size()+j]};
        return r;
    endfunction

    // Push the expected attach-mode stream: data, then CRC MSB first.
    task automatic push_attach(input bit m[$]);
        logic [31:0] c;
        c = model_crc(m, 24, 32'h864CFB);
        foreach (m[i]) begin
            exp_d.push_back(m[i]);
            exp_l.push_back(1'b0);
        end
        for (int j = 23; j >= 0; j--) begin
            exp_d.push_back(c[j]);
            exp_l.push_back(j == 0);
        end
    endtask

    // Drive one frame and record every output transfer until OUT_LAST.
    task automatic run_frame(input bit m[$], input bit mode, input bit rnd);
        int  idx;
        int  cyc;
        bit  done;
        idx = 0;
        cyc = 0;
        done = 1'b0;
        got_d.delete();
        got_l.delete();
        got_done = 0;
        rdy_append = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge CLK);
            OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            MODE = mode;
            IN_VALID = (idx < m.size());
            IN_DATA = IN_VALID ? m[idx] : 1'b0;
            IN_LAST = IN_VALID && (idx == m.size() - 1);
            #1;
            if (CRC_DONE) got_done++;
            if (!mode && idx == m.size() && IN_READY && !(OUT_VALID && OUT_LAST))
                rdy_append = 1'b1;
            if (OUT_VALID && OUT_READY) begin
                got_d.push_back(OUT_DATA);
                got_l.push_back(OUT_LAST);
                if (OUT_LAST) done = 1'b1;
            end
            if (IN_VALID && IN_READY) idx++;
            cyc++;
        end
        got_crc = CRC_VALUE;
        got_ok = CRC_OK;
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_LAST = 1'b0;
        OUT_READY = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        n_total++;
        if ({OUT_VALID, OUT_DATA, OUT_LAST, CRC_DONE, CRC_OK} !== 5'b0)
            $display("FAIL reset_outs: got %b want 00000",
                     {OUT_VALID, OUT_DATA, OUT_LAST, CRC_DONE, CRC_OK});
        else n_pass++;
        n_total++;
        if (CRC_VALUE !== 24'h0)
            $display("FAIL reset_crc: got %h want 000000", CRC_VALUE);
        else n_pass++;
        n_total++;
        if (IN_READY !== 1'b1)
            $display("FAIL reset_in_ready: got %b want 1", IN_READY);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_single_bit(input string tag);
        bit m[$];
        logic gd, gl, ed, el;
        int k;
        m.push_back(1'b1);
        push_attach(m);
        run_frame(m, 1'b0, 1'b0);
        n_total++;
        if (got_crc !== 24'h864CFB)
            $display("FAIL %s crc: got %h want 864cfb", tag, got_crc);
        else n_pass++;
        n_total++;
        if (got_done !== 1)
            $display("FAIL %s done_pulses: got %0d want 1", tag, got_done);
        else n_pass++;
        n_total++;
        if (got_d.size() !== 25)
            $display("FAIL %s length: got %0d want 25", tag, got_d.size());
        else n_pass++;
        k = 0;
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            gd = 1'bx;
            gl = 1'bx;
            if (got_d.size() > 0) begin
                gd = got_d.pop_front();
                gl = got_l.pop_front();
            end
            n_total++;
            if ({gd, gl} !== {ed, el})
                $display("FAIL %s bit%0d: got d%b l%b want d%b l%b",
                         tag, k, gd, gl, ed, el);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_attach_patterns();
        bit m[$];
        logic gd, gl, ed, el;
        int k;
        m.push_back(1'b1);
        m.push_back(1'b0);
        push_attach(m);
        run_frame(m, 1'b0, 1'b0);
        n_total++;
        if (got_crc !== 24'h8AD50D)
            $display("FAIL two_bit crc: got %h want 8ad50d", got_crc);
        else n_pass++;
        k = 0;
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            gd = 1'bx;
            gl = 1'bx;
            if (got_d.size() > 0) begin
                gd = got_d.pop_front();
                gl = got_l.pop_front();
            end
            n_total++;
            if ({gd, gl} !== {ed, el})
                $display("FAIL two_bit bit%0d: got d%b l%b want d%b l%b",
                         k, gd, gl, ed, el);
            else n_pass++;
            k++;
        end
        m.delete();
        for (int i = 0; i < 40; i++) m.push_back(1'b0);
        push_attach(m);
        run_frame(m, 1'b0, 1'b0);
        n_total++;
        if (got_crc !== 24'h0)
            $display("FAIL zeros crc: got %h want 000000", got_crc);
        else n_pass++;
        n_total++;
        if (got_d.size() !== 64)
            $display("FAIL zeros length: got %0d want 64", got_d.size());
        else n_pass++;
        k = 0;
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            gd = 1'bx;
            gl = 1'bx;
            if (got_d.size() > 0) begin
                gd = got_d.pop_front();
                gl = got_l.pop_front();
            end
            n_total++;
            if ({gd, gl} !== {ed, el})
                $display("FAIL zeros bit%0d: got d%b l%b want d%b l%b",
                         k, gd, gl, ed, el);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_check_mode();
        bit m[$];
        logic [31:0] c;
        logic gd, gl, ed, el;
        int k;
        m.push_back(1'b1);
        c = model_crc(m, 24, 32'h864CFB);
        for (int j = 23; j >= 0; j--) m.push_back(c[j]);
        foreach (m[i]) begin
            exp_d.push_back(m[i]);
            exp_l.push_back(i == m.size() - 1);
        end
        run_frame(m, 1'b1, 1'b0);
        n_total++;
        if (got_ok !== 1'b1)
            $display("FAIL check_good ok: got %b want 1", got_ok);
        else n_pass++;
        n_total++;
        if (got_crc !== 24'h0)
            $display("FAIL check_good crc: got %h want 000000", got_crc);
        else n_pass++;
        k = 0;
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            gd = 1'bx;
            gl = 1'bx;
            if (got_d.size() > 0) begin
                gd = got_d.pop_front();
                gl = got_l.pop_front();
            end
            n_total++;
            if ({gd, gl} !== {ed, el})
                $display("FAIL check_good bit%0d: got d%b l%b want d%b l%b",
                         k, gd, gl, ed, el);
            else n_pass++;
            k++;
        end
        m[5] = ~m[5];
        c = model_crc(m, 24, 32'h864CFB);
        run_frame(m, 1'b1, 1'b0);
        n_total++;
        if (got_ok !== 1'b0)
            $display("FAIL check_bad ok: got %b want 0", got_ok);
        else n_pass++;
        n_total++;
        if (got_crc !== c[23:0] || got_crc === 24'h0)
            $display("FAIL check_bad crc: got %h want %h (nonzero)",
                     got_crc, c[23:0]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit m[$];
        logic [31:0] c;
        logic gd, gl, ed, el;
        int k;
        for (int i = 0; i < 30; i++) m.push_back(1'($urandom_range(0, 1)));
        c = model_crc(m, 24, 32'h864CFB);
        push_attach(m);
        run_frame(m, 1'b0, 1'b1);
        n_total++;
        if (got_crc !== c[23:0])
            $display("FAIL bp crc: got %h want %h", got_crc, c[23:0]);
        else n_pass++;
        n_total++;
        if (rdy_append !== 1'b0)
            $display("FAIL bp in_ready_append: got %b want 0", rdy_append);
        else n_pass++;
        n_total++;
        if (got_d.size() !== 54)
            $display("FAIL bp length: got %0d want 54", got_d.size());
        else n_pass++;
        k = 0;
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            gd = 1'bx;
            gl = 1'bx;
            if (got_d.size() > 0) begin
                gd = got_d.pop_front();
                gl = got_l.pop_front();
            end
            n_total++;
            if ({gd, gl} !== {ed, el})
                $display("FAIL bp bit%0d: got d%b l%b want d%b l%b",
                         k, gd, gl, ed, el);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_params();
        bit m[$];
        logic [31:0] c16, c11;
        logic [1:0] q16[$];
        logic [1:0] q11[$];
        logic [1:0] e, g;
        m.push_back(1'b1);
        c16 = model_crc(m, 16, 32'h1021);
        c11 = model_crc(m, 11, 32'h621);
        @(negedge CLK);
        p_valid = 1'b1;
        p_data = 1'b1;
        p_last = 1'b1;
        @(negedge CLK);
        p_valid = 1'b0;
        p_last = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (v16) q16.push_back({d16, l16});
            if (v11) q11.push_back({d11, l11});
            @(negedge CLK);
        end
        n_total++;
        if (crc16 !== 16'h1021)
            $display("FAIL crc16 value: got %h want 1021", crc16);
        else n_pass++;
        n_total++;
        if (crc11 !== 11'h621)
            $display("FAIL crc11 value: got %h want 621", crc11);
        else n_pass++;
        n_total++;
        if (q16.size() !== 17 || q11.size() !== 12)
            $display("FAIL param lengths: got %0d/%0d want 17/12",
                     q16.size(), q11.size());
        else n_pass++;
        for (int i = 0; i < 17; i++) begin
            e = (i == 0) ? 2'b10 : {c16[16-i], 1'(i == 16)};
            g = (q16.size() > 0) ? q16.pop_front() : 2'bxx;
            n_total++;
            if (g !== e) $display("FAIL crc16 bit%0d: got %b want %b", i, g, e);
            else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            e = (i == 0) ? 2'b10 : {c11[11-i], 1'(i == 11)};
            g = (q11.size() > 0) ? q11.pop_front() : 2'bxx;
            n_total++;
            if (g !== e) $display("FAIL crc11 bit%0d: got %b want %b", i, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        @(negedge CLK);
        OUT_READY = 1'b1;
        MODE = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA = 1'b1;
        IN_LAST = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_LAST = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        n_total++;
        if ({OUT_VALID, OUT_DATA, OUT_LAST, CRC_DONE, CRC_OK} !== 5'b0)
            $display("FAIL midrst_outs: got %b want 00000",
                     {OUT_VALID, OUT_DATA, OUT_LAST, CRC_DONE, CRC_OK});
        else n_pass++;
        n_total++;
        if (CRC_VALUE !== 24'h0)
            $display("FAIL midrst_crc: got %h want 000000", CRC_VALUE);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_total++;
        if (IN_READY !== 1'b1)
            $display("FAIL midrst_in_ready: got %b want 1", IN_READY);
        else n_pass++;
        test_single_bit("after_rst");
    endtask

    initial begin
        test_reset();
        test_single_bit("single");
        test_attach_patterns();
        test_check_mode();
        test_backpressure();
        test_params();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc_attach_param.md
Name: crc_attach_param

Overview:
- Parametrised serial CRC engine for the PUSCH transport-block and code-block chain.
- Replaces the fixed 16-bit CRC with a generic width/polynomial LFSR and valid/ready streaming in and out.
- Two modes:
  - Attach (TX): passes data through, then appends the CRC bits MSB-first.
  - Check: passes data through, then flags whether the remainder is zero.
- Sits between the transport-block source and code-block segmentation. Instantiated as CRC24A, CRC24B, CRC16 or CRC11 by parameter.

Parameters:
- CRC_W, 24, CRC length in bits (6..32).
- POLY, 24'h864CFB, generator polynomial without the x^CRC_W term, CRC_W bits wide (CRC24A default).
- SEED, 0, LFSR value loaded at each frame start.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- MODE  in  1  0 = attach, 1 = check; sampled on the first accepted bit of a frame.
- IN_VALID  in  1  input bit valid.
- IN_DATA  in  1  input bit.
- IN_LAST  in  1  marks the last bit of the frame (in check mode, the last received CRC bit).
- IN_READY  out  1  block can accept a bit this cycle.
- OUT_VALID  out  1  output bit valid.
- OUT_DATA  out  1  output bit.
- OUT_LAST  out  1  last bit of the output frame.
- OUT_READY  in  1  downstream accepts the output bit.
- CRC_VALUE  out  CRC_W  final remainder of the last frame.
- CRC_DONE  out  1  one-cycle pulse when CRC_VALUE updates.
- CRC_OK  out  1  check mode: remainder == 0; held until the next CRC_DONE.

Behaviour:
- Reset: state = IDLE, LFSR = SEED, bit counter = 0, mode register = 0. All outputs 0 except IN_READY, which is 1 (see below).
- Handshakes:
  - Input transfer: IN_VALID && IN_READY.
  - Output transfer: OUT_VALID && OUT_READY.
  - adv = !OUT_VALID || OUT_READY (output register free or draining).
  - IN_READY = adv && (state == IDLE || state == DATA). It is combinational from OUT_VALID, OUT_READY and state; no combinational path from IN_VALID.
- LFSR update per accepted input bit (MSB-first Galois):
  - fb = IN_DATA ^ LFSR[CRC_W-1]
  - LFSR <= {LFSR[CRC_W-2:0], 0} ^ (fb ? POLY : 0)
- Output register: on input transfer, OUT_DATA <= IN_DATA and OUT_VALID <= 1. Latency is 1 cycle from input transfer to OUT_VALID. If adv holds and no new bit is loaded, OUT_VALID <= 0.
- State machine (IDLE, DATA, APPEND):
  - IDLE: on the first input transfer, latch MODE, apply the LFSR update from SEED (not from the stale LFSR), go to DATA. If IN_LAST is also set, finish immediately (see last-bit rule).
  - DATA: update the LFSR on each input transfer.
  - Last-bit rule (input transfer with IN_LAST, from IDLE or DATA):
    - Capture the post-update LFSR into CRC_VALUE next cycle and pulse CRC_DONE.
    - Attach mode: OUT_LAST = 0 on this data bit; go to APPEND with a copy of the CRC in a shift register and counter = CRC_W.
    - Check mode: OUT_LAST = 1 on this bit; CRC_OK <= (post-update LFSR == 0); go to IDLE.
    - LFSR reloads SEED on the transition.
  - APPEND: IN_READY = 0. When adv, OUT_DATA <= shift MSB, shift left, counter decrements, OUT_VALID <= 1. When counter == 1, OUT_LAST = 1 and state goes to IDLE. Exactly CRC_W bits are appended, MSB first.
- Backpressure: OUT_DATA/OUT_LAST are held stable while OUT_VALID && !OUT_READY. No bit is dropped or duplicated.
- Back-to-back frames: a new frame may start in the cycle after the final APPEND bit is loaded, with no idle gap required.
- CRC_OK resets to 0 and is updated only in check mode. CRC_VALUE holds its value until the next frame end.
- Mid-frame reset: all state is cleared and the partial frame is discarded; no OUT_LAST is emitted.
- Counter width: $clog2(CRC_W+1).

Test Plan:
1. Defaults, attach, single-bit frame 1 (IN_LAST=1), OUT_READY=1 -> CRC_VALUE=24'h864CFB, CRC_DONE pulse; output stream is 1 followed by 1000_0110_0100_1100_1111_1011, OUT_LAST on the 25th bit.
2. Attach, frame "1,0" -> CRC_VALUE=24'h8AD50D; frame of 40 zeros with SEED=0 -> CRC_VALUE=0, output is 64 zero bits.
3. Check mode: feed the 25-bit output of test 1 as input -> CRC_OK=1. Flip any one bit -> CRC_OK=0, CRC_VALUE≠0.
4. Random 0/1 OUT_READY toggling during the data and APPEND phases -> output bit sequence identical to the OUT_READY=1 run; IN_READY=0 throughout APPEND.
5. CRC_W=16, POLY=16'h1021, single bit 1 -> CRC_VALUE=16'h1021, 16 appended bits. CRC_W=11, POLY=11'h621 -> CRC_VALUE=11'h621.
6. Assert RST low mid-APPEND -> all outputs 0 next cycle, IN_READY=1 after release; following frame matches test 1 exactly.
